pipe_stage_reg_elastic: RTL
===========================

Name: pipe_stage_reg_elastic

Overview:
- Parametrised successor to the fixed MEM/WB pipeline register.
- Carries the write-back payload (RegWrite, MemtoReg, ALU result, memory data, destination register) between two pipeline stages with a valid/ready handshake.
- Uses a 2-entry skid buffer, synchronous flush, and a write-back data mux, so the register file sees only valid, in-order writes under backpressure.
- Sits between the MEM stage and the WB/register-file write port.

Parameters:
- DATA_W, 32, width of ALU result, memory data and write-back data.
- DEST_W, 5, width of destination register index.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush_i  input  1  synchronous squash of all held entries and of the current input.
- in_valid_i  input  1  upstream presents a payload.
- in_ready_o  output  1  stage can accept a payload this cycle.
- RegWrite_i  input  1  payload: register write enable.
- MemtoReg_i  input  1  payload: select memory data for write-back.
- ALUResult_i  input  DATA_W  payload: ALU result.
- MemData_i  input  DATA_W  payload: load data.
- RegDest_i  input  DEST_W  payload: destination register.
- out_valid_o  output  1  head entry is valid.
- out_ready_i  input  1  downstream consumes the head this cycle.
- RegWrite_o  output  1  head RegWrite AND out_valid_o.
- MemtoReg_o  output  1  head MemtoReg.
- ALUResult_o  output  DATA_W  head ALU result.
- MemData_o  output  DATA_W  head memory data.
- RegDest_o  output  DEST_W  head destination.
- WbData_o  output  DATA_W  MemtoReg_o ? MemData_o : ALUResult_o.
- count_o  output  2  occupancy, 0..2.

Behaviour:
- Storage: head register (drives outputs) plus skid register. Occupancy state is EMPTY(0), ONE(1) or FULL(2), and count_o equals the state.
- Reset (rst_n low, asynchronous): state EMPTY; all payload registers 0; out_valid_o=0, RegWrite_o=0, WbData_o=0, count_o=0. in_ready_o=1 once rst_n is high.
- in_ready_o = (state != FULL). It is derived only from registered state, with no combinational path from out_ready_i.
- push = in_valid_i & in_ready_o & ~flush_i.
- pop = out_valid_o & out_ready_i & ~flush_i.
- out_valid_o = (state != EMPTY).
- EMPTY: push loads head and moves to ONE. Latency is 1 cycle: data presented at edge N is visible at outputs after edge N+1.
- ONE, push & pop: head is reloaded from the input; stays ONE.
- ONE, pop only: go to EMPTY.
- ONE, push only: input goes to skid; go to FULL.
- ONE, neither: hold.
- FULL: no push possible. On pop, skid moves to head and the state goes to ONE. Otherwise hold.
- Order is strictly FIFO; entries are never reordered or duplicated.
- Flush has priority over everything:
  - Next edge, the state goes to EMPTY.
  - The input in the flush cycle is dropped.
  - A head presented in the flush cycle is not counted as consumed, and RegWrite_o is 0 that cycle.
  - Payload registers may keep stale data, but RegWrite_o stays 0 whenever out_valid_o=0.
- Held payload is stable while out_valid_o=1 and out_ready_i=0.
- Reset asserted mid-operation discards all entries immediately; no partial write is emitted.
- Widths: all payload fields are stored at exact width, with no extension or truncation. WbData_o is purely combinational from the head.

Decomposition:
- Shared package pipe_pkg:
  - state encoding localparams ST_EMPTY=0, ST_ONE=1, ST_FULL=2;
  - a packed wb_payload_t typedef {RegWrite, MemtoReg, ALUResult, MemData, RegDest}, parametrised through DATA_W/DEST_W package constants.
- One natural sub-module, payload_reg: a DATA_W-generic enable-loaded register with async active-low reset. It is instantiated twice (head, skid).
- The control FSM and the WbData mux stay in the top module.

Test Plan:
- Reset then pass-through: rst_n low for 2 cycles, then push {RegWrite=1, MemtoReg=0, ALU=0x0000_1234, Mem=0xDEAD_BEEF, Dest=5} with out_ready_i=1 -> next cycle out_valid_o=1, RegWrite_o=1, WbData_o=0x1234, RegDest_o=5; all outputs 0 during reset.
- Backpressure: out_ready_i=0, push A=0x11 then B=0x22 -> count_o=2, in_ready_o=0, a third push C is refused; raise out_ready_i -> outputs A, then B, then C in order; count_o returns to 0.
- Simultaneous push/pop in ONE: stream 0x01..0x08 with out_ready_i=1 continuously -> one result per cycle, count_o stays 1, in_ready_o stays 1.
- MemtoReg select: push MemtoReg=1, ALU=0xAAAA_0000, Mem=0x5555_FFFF -> WbData_o=0x5555_FFFF.
- Flush: state FULL, assert flush_i with in_valid_i=1 -> next cycle count_o=0, out_valid_o=0, RegWrite_o=0, input lost, in_ready_o=1.
- Async reset mid-stream: rst_n falls between edges while FULL -> out_valid_o and RegWrite_o drop to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic MEM/WB pipeline register.
// Holds the occupancy encoding and the default write-back payload layout.
package pipe_pkg;

  localparam int PIPE_DATA_W = 32;
  localparam int PIPE_DEST_W = 5;

  // Occupancy encoding; the numeric value is what count_o reports.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_state_e;

  typedef struct packed {
    logic                   RegWrite;
    logic                   MemtoReg;
    logic [PIPE_DATA_W-1:0] ALUResult;
    logic [PIPE_DATA_W-1:0] MemData;
    logic [PIPE_DEST_W-1:0] RegDest;
  } wb_payload_t;

endpackage

// File: rtl/payload_reg.sv
// Width-generic, enable-loaded register with asynchronous active-low clear.
// Used for both the head and the skid slot of the elastic stage.
module payload_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments; the payload is
  // cleared on reset so the write-back data reads 0 until the first load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q <= '0;
    else if (load) q <= d;
  end

endmodule

// File: rtl/pipe_stage_reg_elastic.sv
// Elastic MEM/WB register: 2-entry skid buffer with valid/ready handshake,
// synchronous flush and the write-back data select.
module pipe_stage_reg_elastic
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int DEST_W = PIPE_DEST_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  input  logic [DATA_W-1:0] ALUResult_i,
  input  logic [DATA_W-1:0] MemData_i,
  input  logic [DEST_W-1:0] RegDest_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              RegWrite_o,
  output logic              MemtoReg_o,
  output logic [DATA_W-1:0] ALUResult_o,
  output logic [DATA_W-1:0] MemData_o,
  output logic [DEST_W-1:0] RegDest_o,
  output logic [DATA_W-1:0] WbData_o,
  output logic [1:0]        count_o
);

  localparam int PAYLOAD_W = 2 + 2 * DATA_W + DEST_W;

  occ_state_e           state_q, state_d;
  logic                 push, pop;
  logic                 head_load, skid_load, head_from_skid;
  logic [PAYLOAD_W-1:0] in_payload, head_d, head_q, skid_q;
  logic                 head_reg_write;

  // Ready depends only on registered occupancy, never on out_ready_i.
  assign in_ready_o  = (state_q != ST_FULL);
  assign out_valid_o = (state_q != ST_EMPTY);
  assign count_o     = state_q;

  assign push = in_valid_i & in_ready_o & ~flush_i;
  assign pop  = out_valid_o & out_ready_i & ~flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first so no latch
  // is inferred on paths that do not assign it.
  always_comb begin
    state_d        = state_q;
    head_load      = 1'b0;
    skid_load      = 1'b0;
    head_from_skid = 1'b0;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            head_load = 1'b1;
            state_d   = ST_ONE;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            head_load = 1'b1;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end else if (push) begin
            skid_load = 1'b1;
            state_d   = ST_FULL;
          end
        end
        ST_FULL: begin
          if (pop) begin
            head_load      = 1'b1;
            head_from_skid = 1'b1;
            state_d        = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  assign in_payload = {RegWrite_i, MemtoReg_i, ALUResult_i, MemData_i, RegDest_i};
  assign head_d     = head_from_skid ? skid_q : in_payload;

  payload_reg #(.DATA_W(PAYLOAD_W)) u_head (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (head_load),
    .d     (head_d),
    .q     (head_q)
  );

  payload_reg #(.DATA_W(PAYLOAD_W)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (skid_load),
    .d     (in_payload),
    .q     (skid_q)
  );

  assign {head_reg_write, MemtoReg_o, ALUResult_o, MemData_o, RegDest_o} = head_q;

  // A stale or squashed head must never reach the register file write port.
  assign RegWrite_o = head_reg_write & out_valid_o & ~flush_i;
  assign WbData_o   = MemtoReg_o ? MemData_o : ALUResult_o;

endmodule
